// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter: MEM beats IF, splits 1/2/4-byte accesses, reassembles little-endian.
// Define IFETCH_BUF_EN to add a one-entry fetch buffer that bypasses the RAM on a refetch.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_width_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q;
  logic                owner_mem_q;
  logic                we_q;
  logic [1:0]          cnt_q;
  logic [1:0]          last_q;
  logic [31:0]         wdata_q;
  logic [31:0]         data_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [7:0]          ram_dout_q;
  logic                if_done_q;
  logic                mem_done_q;
  logic [31:0]         if_inst_q;
  logic [31:0]         mem_rdata_q;

  logic [1:0]          cnt_d;
  logic [31:0]         rdata_d;

`ifdef IFETCH_BUF_EN
  logic                buf_vld_q;
  logic [ADDR_W-1:0]   buf_addr_q;
  logic [31:0]         buf_inst_q;
  logic                hit_q;
  logic                buf_hit;

  assign buf_hit = buf_vld_q && (buf_addr_q == if_addr_i[ADDR_W-1:0]);
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  // Lane cnt_q takes the byte arriving this cycle; lower lanes were captured earlier.
  always_comb begin
    cnt_d   = cnt_q + 2'd1;
    rdata_d = data_q;
    rdata_d[8*cnt_q +: 8] = ram_din_i;
  end

  function automatic logic [1:0] last_idx(input logic [1:0] width);
    case (width)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      wdata_q     <= '0;
      data_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
`ifdef IFETCH_BUF_EN
      buf_vld_q   <= 1'b0;
      buf_addr_q  <= '0;
      buf_inst_q  <= '0;
      hit_q       <= 1'b0;
`endif
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= 2'd0;
          data_q <= '0;
          if (mem_req_i) begin
            state_q     <= BUSY;
            owner_mem_q <= 1'b1;
            we_q        <= mem_we_i;
            last_q      <= last_idx(mem_width_i);
            wdata_q     <= mem_wdata_i;
            ram_addr_q  <= mem_addr_i[ADDR_W-1:0];
            ram_we_q    <= mem_we_i;
            ram_dout_q  <= mem_wdata_i[7:0];
`ifdef IFETCH_BUF_EN
            hit_q <= 1'b0;
            if (mem_we_i) buf_vld_q <= 1'b0;
`endif
          end else if (if_req_i) begin
            state_q     <= BUSY;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
`ifdef IFETCH_BUF_EN
            // A hit spends one BUSY cycle with the RAM port left untouched.
            if (buf_hit) begin
              last_q <= 2'd0;
              hit_q  <= 1'b1;
            end else begin
              last_q     <= 2'd3;
              hit_q      <= 1'b0;
              ram_addr_q <= if_addr_i[ADDR_W-1:0];
            end
`else
            last_q     <= 2'd3;
            ram_addr_q <= if_addr_i[ADDR_W-1:0];
`endif
          end
        end
        BUSY: begin
          if (!we_q) data_q <= rdata_d;
          if (cnt_q == last_q) begin
            state_q  <= DONE;
            ram_we_q <= 1'b0;
            if (owner_mem_q) begin
              mem_done_q <= 1'b1;
              if (!we_q) mem_rdata_q <= rdata_d;
            end else begin
              if_done_q <= 1'b1;
`ifdef IFETCH_BUF_EN
              if (hit_q) begin
                if_inst_q <= buf_inst_q;
              end else begin
                if_inst_q  <= rdata_d;
                buf_vld_q  <= 1'b1;
                buf_addr_q <= ram_addr_q - ADDR_W'(3);
                buf_inst_q <= rdata_d;
              end
`else
              if_inst_q <= rdata_d;
`endif
            end
          end else begin
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            ram_dout_q <= wdata_q[8*cnt_d +: 8];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_inst_o   = if_inst_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_dout_o  = ram_dout_q;
  assign stall_mem_o = mem_req_i & ~mem_done_q;
  assign stall_if_o  = (if_req_i & ~if_done_q) | stall_mem_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a combinational-read byte RAM model.
module tb_mem_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_inst;
  logic          if_done;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_width = '0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic          stall_if;
  logic          stall_mem;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic [AW-1:0] addr_log [0:15];
  logic          we_log   [0:15];
  logic          sif_log  [0:15];
  logic          ifd_log  [0:15];

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int cnt;
  logic [AW-1:0] pre_addr;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(if_inst), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_width_i(mem_width),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_dout_o(ram_dout), .ram_din_i(ram_din),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  assign ram_din = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps edge by edge until the selected done pulse, bounded at 15 edges (n=0 on timeout).
  task automatic run(input bit is_mem, output int lat);
    lat = 0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      addr_log[i] = ram_addr;
      we_log[i]   = ram_we;
      sif_log[i]  = stall_if;
      ifd_log[i]  = if_done;
      if (is_mem ? mem_done : if_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < (1<<AW); a++) ram[a] = 8'h00;
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05;
    ram[17'h1FFFE] = 8'h11; ram[17'h1FFFF] = 8'h22;
    ram[17'h00000] = 8'h33; ram[17'h00001] = 8'h44;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;

    // Plain fetch
    if_addr = 32'h100; if_req = 1'b1;
    #1;
    chk("fetch_stall_if", 32'(stall_if), 32'h1);
    chk("fetch_stall_mem", 32'(stall_mem), 32'h0);
    run(1'b0, n);
    chk("fetch_lat", n, 5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fetch_addr%0d", k), 32'(addr_log[k+1]), 32'h100 + k);
    chk("fetch_inst", if_inst, 32'h00000513);
    chk("fetch_stall_at_done", 32'(stall_if), 32'h0);
    drop_reqs();
    chk("fetch_done_pulse", 32'(if_done), 32'h0);
    chk("fetch_inst_hold", if_inst, 32'h00000513);

    // SW 0xDEADBEEF @0x20
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
    run(1'b1, n);
    chk("sw_lat", n, 5);
    cnt = 0;
    for (int k = 1; k <= 5; k++) cnt += int'(we_log[k]);
    chk("sw_we_cycles", cnt, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("sw_addr%0d", k), 32'(addr_log[k+1]), 32'h20 + k);
    chk("sw_ram", {ram[17'h23], ram[17'h22], ram[17'h21], ram[17'h20]}, 32'hDEADBEEF);
    drop_reqs();

    // LB @0x22, LH @0x21
    mem_req = 1'b1; mem_width = 2'b00; mem_addr = 32'h22;
    run(1'b1, n);
    chk("lb_lat", n, 2);
    chk("lb_rdata", mem_rdata, 32'h000000AD);
    drop_reqs();
    mem_req = 1'b1; mem_width = 2'b01; mem_addr = 32'h21;
    run(1'b1, n);
    chk("lh_lat", n, 3);
    chk("lh_rdata", mem_rdata, 32'h0000ADBE);
    drop_reqs();

    // Simultaneous requests: LW first, fetch waits
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_width = 2'b10; mem_addr = 32'h20;
    run(1'b1, n);
    chk("arb_mem_lat", n, 5);
    chk("arb_rdata", mem_rdata, 32'hDEADBEEF);
    for (int k = 1; k <= 5; k++) chk($sformatf("arb_stall_if%0d", k), 32'(sif_log[k]), 32'h1);
    for (int k = 1; k <= 5; k++) chk($sformatf("arb_no_ifdone%0d", k), 32'(ifd_log[k]), 32'h0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    chk("arb_stall_idle", 32'(stall_if), 32'h1);
    run(1'b0, n);
    chk("arb_if_lat", n, 5);
    chk("arb_if_addr0", 32'(addr_log[1]), 32'h100);
    chk("arb_if_inst", if_inst, 32'h00000513);
    drop_reqs();

    // LW wrapping past the top of RAM
    mem_req = 1'b1; mem_width = 2'b11; mem_addr = 32'h0001FFFE;
    run(1'b1, n);
    chk("wrap_lat", n, 5);
    chk("wrap_addr0", 32'(addr_log[1]), 32'h1FFFE);
    chk("wrap_addr1", 32'(addr_log[2]), 32'h1FFFF);
    chk("wrap_addr2", 32'(addr_log[3]), 32'h0);
    chk("wrap_addr3", 32'(addr_log[4]), 32'h1);
    chk("wrap_rdata", mem_rdata, 32'h44332211);
    drop_reqs();

    // Refetch 0x100 (buffer hit when compiled in)
    pre_addr = ram_addr;
    if_req = 1'b1; if_addr = 32'h100;
    run(1'b0, n);
`ifdef IFETCH_BUF_EN
    chk("refetch_lat", n, 2);
    chk("refetch_addr_kept", 32'(addr_log[1]), 32'(pre_addr));
    chk("refetch_addr_kept2", 32'(addr_log[2]), 32'(pre_addr));
`else
    chk("refetch_lat", n, 5);
    chk("refetch_addr0", 32'(addr_log[1]), 32'h100);
`endif
    chk("refetch_inst", if_inst, 32'h00000513);
    drop_reqs();

    // SB elsewhere, then refetch goes back to RAM
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b00; mem_addr = 32'h300; mem_wdata = 32'h0000005A;
    run(1'b1, n);
    chk("sb_lat", n, 2);
    chk("sb_ram", 32'(ram[17'h300]), 32'h5A);
    drop_reqs();
    if_req = 1'b1; if_addr = 32'h100;
    run(1'b0, n);
    chk("post_sb_fetch_lat", n, 5);
    chk("post_sb_fetch_addr0", 32'(addr_log[1]), 32'h100);
    drop_reqs();

    // Reset during the third byte of a store
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h01020304;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstmid_addr", 32'(ram_addr), 32'h42);
    chk("rstmid_we", 32'(ram_we), 32'h1);
    chk("rstmid_dout", 32'(ram_dout), 32'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_we_after", 32'(ram_we), 32'h0);
    chk("rstmid_done_after", 32'(mem_done), 32'h0);
    chk("rstmid_addr_after", 32'(ram_addr), 32'h0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    cnt = 0;
    repeat (4) begin @(posedge clk); #1; cnt += int'(mem_done) + int'(ram_we); end
    chk("rstmid_quiet", cnt, 0);
    chk("rstmid_byte2", 32'(ram[17'h42]), 32'h02);
    chk("rstmid_byte3", 32'(ram[17'h43]), 32'h00);
    mem_req = 1'b1; mem_width = 2'b00; mem_addr = 32'h41;
    run(1'b1, n);
    chk("rstmid_lb_lat", n, 2);
    chk("rstmid_lb_rdata", mem_rdata, 32'h00000003);
    drop_reqs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
